fust_issue_sched: RTL

Per-functional-unit issue scheduler for the issue stage. It tracks one status entry per FU slot: scalar ALU, scalar LD/ST, branch, matrix LD/ST and GEMM. Each cycle it picks the oldest ready, non-speculative entry and presents it for issue. It also publishes the per-FU state vector consumed by the issue datapath, and handles freeze, branch squash and writeback release.

---
 rtl/fust_issue_sched_if.sv | 35 +++
 rtl/fust_issue_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fust_issue_sched_if.sv
// Dispatch / issue / writeback bundle of the FU status-table scheduler.
// master = pipeline side, slave = scheduler side.
`timescale 1ns/1ps
interface fust_issue_sched_if #(
    parameter int NUM_FU = 5,
    parameter int FU_W   = 3
);
    logic                       alloc_en;
    logic [FU_W-1:0]            alloc_fu;
    logic                       alloc_spec;
    logic                       alloc_stall;
    logic [NUM_FU-1:0]          src_ready;
    logic                       issue_valid;
    logic [FU_W-1:0]            issue_fu;
    logic                       issue_ready;
    logic [NUM_FU-1:0]          wb_done;
    logic                       freeze;
    logic                       branch_miss;
    logic                       branch_resolved;
    logic [NUM_FU-1:0][1:0]     fust_state;

    modport master (
        output alloc_en, alloc_fu, alloc_spec, src_ready,
        output issue_ready, wb_done, freeze,
        output branch_miss, branch_resolved,
        input  alloc_stall, issue_valid, issue_fu, fust_state
    );

    modport slave (
        input  alloc_en, alloc_fu, alloc_spec, src_ready,
        input  issue_ready, wb_done, freeze,
        input  branch_miss, branch_resolved,
        output alloc_stall, issue_valid, issue_fu, fust_state
    );
endinterface

// File: rtl/fust_issue_sched.sv
// Per-FU status table and oldest-ready issue selector.
// Optional ISSUE_PERF_EN adds perf_issued / perf_stall counters.
`timescale 1ns/1ps
module fust_issue_sched #(
    parameter int NUM_FU = 5,
    parameter int AGE_W  = 4,
    parameter int FU_W   = 3
) (
    input  logic                 CLK,
    input  logic                 nRST,
    fust_issue_sched_if.slave    bus
`ifdef ISSUE_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } fu_st_e;

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    fu_st_e             state_q [NUM_FU];
    fu_st_e             state_d [NUM_FU];
    logic [AGE_W-1:0]   age_q   [NUM_FU];
    logic [AGE_W-1:0]   age_d   [NUM_FU];
    logic [NUM_FU-1:0]  spec_q;
    logic [NUM_FU-1:0]  spec_d;

    logic               tgt_busy;
    logic               spec_drop;
    logic               alloc_stall;
    logic               alloc_ok;
    logic               sel_found;
    logic [AGE_W-1:0]   sel_age;
    logic [FU_W-1:0]    sel_fu;
    logic               issue_valid;
    logic               issue_acc;
    logic [NUM_FU-1:0][1:0] fust_state;

    // State register: per-entry FSM state, age and speculation flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_q[i] <= ST_IDLE;
                age_q[i]   <= '0;
            end
            spec_q <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_q[i] <= state_d[i];
                age_q[i]   <= age_d[i];
            end
            spec_q <= spec_d;
        end
    end

    // Output logic: stall, alloc accept and oldest-ready selection.
    always_comb begin
        tgt_busy  = 1'b0;
        sel_found = 1'b0;
        sel_age   = '0;
        sel_fu    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (bus.alloc_fu == FU_W'(i) && state_q[i] != ST_IDLE)
                tgt_busy = 1'b1;
        end
        // Strict compare keeps the lowest index on an age tie.
        for (int i = 0; i < NUM_FU; i++) begin
            if (state_q[i] == ST_READY && !spec_q[i] &&
                (!sel_found || age_q[i] > sel_age)) begin
                sel_found = 1'b1;
                sel_age   = age_q[i];
                sel_fu    = FU_W'(i);
            end
        end
        // A speculative alloc in a miss cycle is discarded, never stalled.
        spec_drop   = bus.branch_miss & bus.alloc_spec;
        alloc_stall = bus.alloc_en & tgt_busy & ~spec_drop;
        alloc_ok    = bus.alloc_en & ~tgt_busy & ~spec_drop & ~bus.freeze;
        issue_valid = sel_found & ~bus.freeze;
        issue_acc   = issue_valid & bus.issue_ready;
        for (int i = 0; i < NUM_FU; i++)
            fust_state[i] = state_q[i];
    end

    assign bus.alloc_stall = alloc_stall;
    assign bus.issue_valid = issue_valid;
    assign bus.issue_fu    = sel_fu;
    assign bus.fust_state  = fust_state;

    // Next-state logic: per-entry transitions, aging and branch handling.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            state_d[i] = state_q[i];
            age_d[i]   = age_q[i];
            spec_d[i]  = spec_q[i];
            if (state_q[i] != ST_IDLE && !bus.freeze && age_q[i] != AGE_MAX)
                age_d[i] = age_q[i] + AGE_W'(1);
            case (state_q[i])
                ST_IDLE: begin
                    if (alloc_ok && bus.alloc_fu == FU_W'(i)) begin
                        state_d[i] = ST_WAIT;
                        age_d[i]   = '0;
                        spec_d[i]  = bus.alloc_spec;
                    end
                end
                ST_WAIT: begin
                    if (bus.branch_miss && spec_q[i])
                        state_d[i] = ST_IDLE;
                    else if (!bus.freeze && bus.src_ready[i])
                        state_d[i] = ST_READY;
                end
                ST_READY: begin
                    if (bus.branch_miss && spec_q[i])
                        state_d[i] = ST_IDLE;
                    else if (issue_acc && sel_fu == FU_W'(i))
                        state_d[i] = ST_EXEC;
                end
                ST_EXEC: begin
                    if (bus.wb_done[i])
                        state_d[i] = ST_IDLE;
                end
                default: state_d[i] = ST_IDLE;
            endcase
            if (bus.branch_resolved)
                spec_d[i] = 1'b0;
            if (state_d[i] == ST_IDLE) begin
                age_d[i]  = '0;
                spec_d[i] = 1'b0;
            end
        end
    end

`ifdef ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q,  perf_stall_d;

    // Perf next values: accepted issues, and dispatch/freeze stall cycles.
    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_stall_d  = perf_stall_q;
        if (issue_acc)
            perf_issued_d = perf_issued_q + 32'd1;
        if (alloc_stall || (bus.freeze && sel_found))
            perf_stall_d = perf_stall_q + 32'd1;
    end

    // Perf counter registers, wrapping at 2^32.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
